sha_stream_arbiter: RTL

//  Packet-atomic round-robin arbiter sharing one sha224/sha256-family byte-stream core between NREQ

---
 rtl/sha_stream_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sha_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sha_stream_arbiter
// Description : Packet-atomic round-robin arbiter sharing one sha224/sha256
//               byte-stream hash core between NREQ requesters. The arbiter
//               locks onto one requester from its first accepted byte until
//               its tlast byte, then re-arbitrates. One registered output
//               stage drives the hash core input.
// Ports       : clk, rstn           clock, asynchronous active-low reset
//               s_tvalid/s_tready   per-requester byte handshake
//               s_tlast/s_tid/...   per-requester last flag, id, byte
//               m_tvalid/m_tready   hash-core byte handshake
//               m_tlast/m_tid/...   hash-core last flag, id, byte
//               m_tsrc              requester index of the current m_* beat
//               busy                high while locked to a requester
// Revision    : 1.0 - initial release
// ============================================================================
module sha_stream_arbiter #(
    parameter  int NREQ = 4,
    parameter  int IDW  = 32,
    localparam int SW   = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NREQ-1:0]     s_tvalid,
    output logic [NREQ-1:0]     s_tready,
    input  logic [NREQ-1:0]     s_tlast,
    input  logic [NREQ*IDW-1:0] s_tid,
    input  logic [NREQ*8-1:0]   s_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [IDW-1:0]      m_tid,
    output logic [7:0]          m_tdata,
    output logic [SW-1:0]       m_tsrc,
    output logic                busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   gnt_q, gnt_d;
    logic [SW-1:0]   last_q, last_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            m_tlast_q, m_tlast_d;
    logic [IDW-1:0]  m_tid_q, m_tid_d;
    logic [7:0]      m_tdata_q, m_tdata_d;
    logic [SW-1:0]   m_tsrc_q, m_tsrc_d;

    // Round-robin search: first requesting index strictly after the last grant.
    logic            win_found;
    logic [SW-1:0]   win_idx;
    logic [SW-1:0]   cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = SW'((int'(last_q) + k) % NREQ);
            if (!win_found && s_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Lanes of the locked requester.
    logic            sel_tvalid;
    logic            sel_tlast;
    logic [7:0]      sel_tdata;
    logic [IDW-1:0]  sel_tid;
    logic            slot_free;
    logic            accept;

    assign sel_tvalid = s_tvalid[gnt_q];
    assign sel_tlast  = s_tlast[gnt_q];
    assign sel_tdata  = s_tdata[int'(gnt_q)*8 +: 8];
    assign sel_tid    = s_tid[int'(gnt_q)*IDW +: IDW];

    // The output register can take a new byte when empty or draining this cycle.
    assign slot_free  = ~m_tvalid_q | m_tready;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;
        m_tdata_d  = m_tdata_q;
        m_tsrc_d   = m_tsrc_q;
        s_tready   = '0;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_BUSY;
                    gnt_d   = win_idx;
                    last_d  = win_idx;
                end
            end
            ST_BUSY: begin
                s_tready[gnt_q] = slot_free;
                accept          = sel_tvalid & slot_free;
                // Lock is held through gaps; only an accepted tlast releases it.
                if (accept && sel_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The output stage keeps draining in IDLE so the tlast beat can leave.
        if (accept) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = sel_tlast;
            m_tid_d    = sel_tid;
            m_tdata_d  = sel_tdata;
            m_tsrc_d   = gnt_q;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            last_q     <= SW'(NREQ - 1);
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
            m_tdata_q  <= '0;
            m_tsrc_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tid_q    <= m_tid_d;
            m_tdata_q  <= m_tdata_d;
            m_tsrc_q   <= m_tsrc_d;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tid    = m_tid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tsrc   = m_tsrc_q;
    assign busy     = (state_q == ST_BUSY);

endmodule
`default_nettype wire
